bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have port CLK  input  1  the single clock; all logic changes on its rising edge.
REQ-002 SHALL have port CLR  input  1  reset; synchronous, active-high.
REQ-003 SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-004 SHALL have ports we0/we1  input  1  1=write, 0=read; sampled with req.
REQ-005 SHALL have ports addr0/addr1  input  4  word address.
REQ-006 SHALL have ports wdata0/wdata1  input  8  write data.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse.
REQ-009 SHALL have port rdata  output  8  read data, shared by both requesters, qualified by rvalid0/rvalid1.
REQ-010 SHALL have ports bram_we  output  1, bram_addr  output  4, bram_din  output  8, which drive the 16x8 single-port block RAM wea/addra/dina.
REQ-011 SHALL have port bram_dout  input  8, from the RAM douta; valid one cycle after the address is sampled.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL run an FSM with states IDLE, ACC and RWAIT.
REQ-014 SHALL arbitrate in IDLE at each edge where req0|req1=1: latch the owner and register that owner's we/addr/wdata onto bram_we/bram_addr/bram_din; next state is ACC.
REQ-015 SHALL assert gnt[owner] for exactly the ACC cycle and never assert both grants in the same cycle.
REQ-016 SHALL hold the BRAM outputs stable during ACC; the RAM performs the operation at the edge ending ACC.
REQ-017 SHALL, for a write, go ACC->IDLE, with bram_we low from that edge and no rvalid pulse.
REQ-018 SHALL, for a read, go ACC->RWAIT, then capture bram_dout into rdata at the edge ending RWAIT, go to IDLE, and pulse rvalid[owner] for the following cycle.
REQ-019 SHALL give latency from the arbitration edge: gnt in cycle +1; read rvalid/rdata in cycle +3; next arbitration edge at +2 (write) or +3 (read).
REQ-020 SHALL hold rdata until the next read capture.
REQ-021 SHALL treat a req still high at the next IDLE arbitration edge as a new request; requesters drop req after seeing gnt.
REQ-022 SHALL ignore req changes outside IDLE.
REQ-023 SHALL keep bram_we=0 in every cycle except the ACC cycle of a write.

Reset
REQ-024 SHALL, with CLR high at an edge, force state IDLE and gnt0/gnt1/rvalid0/rvalid1/bram_we/busy=0, rdata=0, bram_addr=0, bram_din=0, and round-robin pointer "last=1".
REQ-025 SHALL, when CLR is applied mid-operation, abandon the transaction with no rvalid; RAM contents are not altered beyond an already-committed write.

Configuration
REQ-026 SHALL, with ROUND_ROBIN_EN defined, arbitrate round-robin: when both request, grant the requester not served last, and update the pointer on every grant.
REQ-027 SHALL, with ROUND_ROBIN_EN undefined, use fixed priority with requester 0 always winning; the pointer logic is absent.

Structure
REQ-028 SHALL keep ADDR_W=4, DATA_W=8 and the IDLE/ACC/RWAIT state encodings in the shared package bram_pkg.
REQ-029 SHALL place the two-way winner selection (round-robin or fixed) in sub-module rr_pick2.

Verification
REQ-030 SHALL cover single write: req0,we0=1,addr0=3,wdata0=8'hA5 -> gnt0 at +1, bram_we=1/addr=3/din=A5 for one cycle only, no rvalid.
REQ-031 SHALL cover read-back: after REQ-030, req1,we1=0,addr1=3 -> gnt1 at +1, rvalid1 at +3 with rdata=8'hA5, rvalid0=0.
REQ-032 SHALL cover contention: req0 and req1 reads held high continuously with ROUND_ROBIN_EN -> grants alternate 0,1,0,1; without the macro -> only gnt0.
REQ-033 SHALL cover address wrap: write addr 15=8'h0F and addr 0=8'hF0, then read both -> 8'h0F and 8'hF0 respectively.
REQ-034 SHALL cover reset mid-read: CLR in the RWAIT cycle -> no rvalid, all outputs 0 next cycle, and the first grant after reset goes to requester 0 under simultaneous requests.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared widths and FSM state encoding for the BRAM arbiter.
package bram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        RWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/bram_arbiter_rr_pick2.sv
// Two-way winner selection: round-robin with ROUND_ROBIN_EN, else fixed priority to requester 0.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
`ifdef ROUND_ROBIN_EN
    input  logic last,
`endif
    output logic pick
);

    always_comb begin
`ifdef ROUND_ROBIN_EN
        // On contention favour whoever was not served last.
        pick = (req0 && req1) ? ~last : req1;
`else
        pick = ~req0 & req1;
`endif
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for a 16x8 single-port block RAM (IDLE -> ACC -> [RWAIT] -> IDLE).
// Optional macro ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module bram_arbiter
    import bram_pkg::*;
(
    input  logic              CLK,
    input  logic              CLR,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy
);

    state_t state;
    logic   owner;
    logic   pick;

`ifdef ROUND_ROBIN_EN
    logic last;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .pick (pick)
    );
`else
    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .pick (pick)
    );
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= IDLE;
            owner     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
`ifdef ROUND_ROBIN_EN
            last      <= 1'b1;
`endif
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= pick;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        bram_we   <= pick ? we1    : we0;
                        bram_addr <= pick ? addr1  : addr0;
                        bram_din  <= pick ? wdata1 : wdata0;
`ifdef ROUND_ROBIN_EN
                        last      <= pick;
`endif
                        state     <= ACC;
                    end
                end
                ACC: begin
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    bram_we <= 1'b0;
                    // The RAM commits a write at this edge; reads still need the data cycle.
                    state   <= bram_we ? IDLE : RWAIT;
                end
                RWAIT: begin
                    rdata   <= bram_dout;
                    rvalid0 <= ~owner;
                    rvalid1 <= owner;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: latency-rule reference model plus directed literal checks.
module tb_bram_arbiter;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, bram_we, busy;
    logic [7:0] rdata, bram_din, bram_dout;
    logic [3:0] bram_addr;

    bram_arbiter dut (
        .CLK(CLK), .CLR(CLR),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // 16x8 single-port RAM with registered read port
    logic [7:0] ram [16];
    always @(posedge CLK) begin
        if (bram_we) ram[bram_addr] <= bram_din;
        bram_dout <= ram[bram_addr];
    end

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: outputs derived from the latency rules relative to the arbitration edge
    typedef struct packed {
        logic       g0, g1, rv0, rv1, we, busy;
        logic [3:0] addr;
        logic [7:0] din, rdata;
    } exp_t;

    exp_t        e;
    bit          model_on = 0;
    logic [7:0]  ref_mem [16];

    initial begin
        bit          have_tx = 0;
        bit          towner = 0, twe = 0, m_last = 1, w, free;
        logic [3:0]  taddr = '0;
        logic [7:0]  tdata = '0;
        int unsigned edge_n = 0, tk = 0, d;
        e = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        forever begin
            @(posedge CLK);
            edge_n++;
            d = edge_n - tk;
            // a write is committed by the RAM at the edge after arbitration, even if CLR is high
            if (have_tx && twe && d == 1) ref_mem[taddr] = tdata;
            e.g0 = 0; e.g1 = 0; e.rv0 = 0; e.rv1 = 0; e.we = 0; e.busy = 0;
            if (CLR) begin
                e = '0;
                have_tx = 0;
                m_last = 1;
                model_on = 1;
            end else begin
                if (have_tx && !twe && d == 1) e.busy = 1;
                if (have_tx && !twe && d == 2) begin
                    e.rdata = ref_mem[taddr];
                    e.rv0 = !towner;
                    e.rv1 = towner;
                end
                free = !have_tx || (d >= (twe ? 2 : 3));
                if (free && (req0 || req1)) begin
`ifdef ROUND_ROBIN_EN
                    w = (req0 && req1) ? !m_last : req1;
`else
                    w = !req0;
`endif
                    have_tx = 1;
                    tk      = edge_n;
                    towner  = w;
                    twe     = w ? we1 : we0;
                    taddr   = w ? addr1 : addr0;
                    tdata   = w ? wdata1 : wdata0;
                    m_last  = w;
                    e.g0 = !w; e.g1 = w; e.we = twe; e.busy = 1;
                    e.addr = taddr; e.din = tdata;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (model_on) begin
                chk("m_gnt0", gnt0, e.g0);
                chk("m_gnt1", gnt1, e.g1);
                chk("m_rvalid0", rvalid0, e.rv0);
                chk("m_rvalid1", rvalid1, e.rv1);
                chk("m_bram_we", bram_we, e.we);
                chk("m_busy", busy, e.busy);
                chk("m_bram_addr", bram_addr, e.addr);
                chk("m_bram_din", bram_din, e.din);
                chk("m_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one request for a single arbitration edge; returns in cycle +1.
    task automatic issue(input bit who, input bit w, input logic [3:0] a, input logic [7:0] dat);
        if (who) begin req1 = 1; we1 = w; addr1 = a; wdata1 = dat; end
        else     begin req0 = 1; we0 = w; addr0 = a; wdata0 = dat; end
        step();
        req0 = 0;
        req1 = 0;
    endtask

    initial begin
        bit         seq [4];
        int         ng;
        CLR = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) step();
        CLR = 0;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_addr", bram_addr, 4'h0);
        chk("rst_we", bram_we, 0);

        // fill the RAM so every later read has a defined reference value
        for (int i = 0; i < 16; i++) begin
            issue(i[0], 1, 4'(i), 8'(i * 37 + 11));
            step();
        end

        // single write
        issue(0, 1, 4'd3, 8'hA5);
        chk("wr_gnt0", gnt0, 1);
        chk("wr_gnt1", gnt1, 0);
        chk("wr_we", bram_we, 1);
        chk("wr_addr", bram_addr, 4'd3);
        chk("wr_din", bram_din, 8'hA5);
        step();
        chk("wr_we_off", bram_we, 0);
        chk("wr_busy_off", busy, 0);
        chk("wr_no_rv", rvalid0 | rvalid1, 0);

        // read-back by requester 1
        issue(1, 0, 4'd3, 8'h00);
        chk("rd_gnt1", gnt1, 1);
        chk("rd_gnt0", gnt0, 0);
        step();
        chk("rd_rv_early", rvalid1, 0);
        step();
        chk("rd_rvalid1", rvalid1, 1);
        chk("rd_rvalid0", rvalid0, 0);
        chk("rd_rdata", rdata, 8'hA5);

        // address wrap
        issue(0, 1, 4'd15, 8'h0F); step();
        issue(1, 1, 4'd0, 8'hF0);  step();
        issue(0, 0, 4'd15, 8'h00); step(); step();
        chk("wrap_rv15", rvalid0, 1);
        chk("wrap_rd15", rdata, 8'h0F);
        issue(1, 0, 4'd0, 8'h00);  step(); step();
        chk("wrap_rv0", rvalid1, 1);
        chk("wrap_rd0", rdata, 8'hF0);

        // contention: both reads held high; last served was requester 1
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 4'd1; addr1 = 4'd2;
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gnt0 || gnt1) begin
                if (ng < 4) seq[ng] = gnt1;
                ng++;
            end
        end
        req0 = 0; req1 = 0;
        chk("cont_ngrants", 32'(ng), 32'd4);
`ifdef ROUND_ROBIN_EN
        chk("cont_g0", seq[0], 0);
        chk("cont_g1", seq[1], 1);
        chk("cont_g2", seq[2], 0);
        chk("cont_g3", seq[3], 1);
`else
        chk("cont_g0", seq[0], 0);
        chk("cont_g1", seq[1], 0);
        chk("cont_g2", seq[2], 0);
        chk("cont_g3", seq[3], 0);
`endif
        step();

        // reset during RWAIT
        issue(1, 0, 4'd5, 8'h00);
        step();
        chk("mr_busy_rwait", busy, 1);
        CLR = 1;
        step();
        CLR = 0;
        chk("mr_rv0", rvalid0, 0);
        chk("mr_rv1", rvalid1, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rdata", rdata, 8'h00);
        chk("mr_addr", bram_addr, 4'h0);
        chk("mr_gnt", gnt0 | gnt1, 0);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        step();
        req0 = 0; req1 = 0;
        chk("mr_first_gnt0", gnt0, 1);
        chk("mr_first_gnt1", gnt1, 0);
        repeat (3) step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            req0   = ($urandom_range(0, 1) == 1);
            req1   = ($urandom_range(0, 1) == 1);
            we0    = ($urandom_range(0, 1) == 1);
            we1    = ($urandom_range(0, 1) == 1);
            addr0  = 4'($urandom_range(0, 15));
            addr1  = 4'($urandom_range(0, 15));
            wdata0 = 8'($urandom_range(0, 255));
            wdata1 = 8'($urandom_range(0, 255));
            CLR    = ($urandom_range(0, 63) == 0);
            step();
        end
        CLR = 0; req0 = 0; req1 = 0;
        repeat (5) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
